// File: rtl/hir_banked_mem_model.sv
// Multi-bank memory responder: per-bank read/write ports, configurable read
// latency pipeline, pattern fill sequencer after reset/reinit, and a
// saturating counter of out-of-range accesses.
module hir_banked_mem_model #(
  parameter int unsigned        NBANKS     = 16,
  parameter int unsigned        DEPTH      = 16,
  parameter int unsigned        ADDR_W     = 4,
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        RD_LAT     = 1,
  parameter int unsigned        INIT_MODE  = 1,
  parameter int unsigned        INIT_CONST = 255,
  parameter logic [DATA_W-1:0]  ERR_VALUE  = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reinit,
  output logic                     ready,
  input  logic [NBANKS-1:0]        rd_en,
  input  logic [NBANKS*ADDR_W-1:0] rd_addr,
  output logic [NBANKS-1:0]        rd_valid,
  output logic [NBANKS*DATA_W-1:0] rd_data,
  input  logic [NBANKS-1:0]        wr_en,
  input  logic [NBANKS*ADDR_W-1:0] wr_addr,
  input  logic [NBANKS*DATA_W-1:0] wr_data,
  output logic [15:0]              err_cnt
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    S_FILL,
    S_READY
  } state_e;

  state_e                 state_q, state_d;
  idx_t                   fill_cnt_q, fill_cnt_d;
  logic                   fill_we;
  logic [DATA_W-1:0]      fill_val;
  logic                   access_ok;

  logic [DATA_W-1:0]      mem_q [NBANKS][DEPTH];

  logic [NBANKS-1:0]      rd_acc;
  logic [NBANKS-1:0]      wr_acc;
  logic [DATA_W-1:0]      rd_word [NBANKS];
  logic [31:0]            err_inc;
  logic [31:0]            err_sum;
  logic [15:0]            err_cnt_q, err_cnt_d;

  logic [NBANKS-1:0]      pv_q     [RD_LAT];
  logic [DATA_W-1:0]      pd_q     [RD_LAT][NBANKS];
  logic [NBANKS-1:0]      stg_v_in [RD_LAT];
  logic [DATA_W-1:0]      stg_d_in [RD_LAT][NBANKS];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  // State and fill-counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FILL;
      fill_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  // Next-state: fill one word per cycle, then serve accesses; reinit restarts.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    if (reinit) begin
      state_d    = S_FILL;
      fill_cnt_d = '0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (fill_cnt_q == idx_t'(DEPTH - 1)) begin
            state_d    = S_READY;
            fill_cnt_d = '0;
          end else begin
            fill_cnt_d = fill_cnt_q + idx_t'(1);
          end
        end
        S_READY: state_d = S_READY;
        default: state_d = S_FILL;
      endcase
    end
  end

  assign ready = (state_q == S_READY);

  // Accesses in the reinit cycle are dropped: the pipeline is flushed at the
  // same edge, so accepting them would only leave half-done side effects.
  assign access_ok = ready && !reinit;
  assign fill_we   = (state_q == S_FILL) && !reinit;

  // Fill pattern for the word currently addressed by the sequencer.
  always_comb begin
    if (INIT_MODE == 0) begin
      fill_val = '0;
    end else if (INIT_MODE == 1) begin
      fill_val = DATA_W'(32'(fill_cnt_q) + 32'd1);
    end else begin
      fill_val = DATA_W'(INIT_CONST);
    end
  end

  // Per-bank address decode, read-first lookup and illegal-access tally.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] wa;
    rd_acc  = '0;
    wr_acc  = '0;
    err_inc = '0;
    for (int unsigned b = 0; b < NBANKS; b++) begin
      ra         = rd_addr[b*ADDR_W +: ADDR_W];
      wa         = wr_addr[b*ADDR_W +: ADDR_W];
      rd_word[b] = ERR_VALUE;
      if (in_range(ra)) begin
        rd_word[b] = mem_q[b][idx_t'(ra)];
      end
      if (access_ok && rd_en[b]) begin
        rd_acc[b] = 1'b1;
        if (!in_range(ra)) begin
          err_inc = err_inc + 32'd1;
        end
      end
      if (access_ok && wr_en[b]) begin
        if (in_range(wa)) begin
          wr_acc[b] = 1'b1;
        end else begin
          err_inc = err_inc + 32'd1;
        end
      end
    end
  end

  // Memory array: sequencer fill or accepted in-range writes; never reset.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < NBANKS; b++) begin
      if (fill_we) begin
        mem_q[b][fill_cnt_q] <= fill_val;
      end else if (wr_acc[b]) begin
        mem_q[b][idx_t'(wr_addr[b*ADDR_W +: ADDR_W])] <= wr_data[b*DATA_W +: DATA_W];
      end
    end
  end

  // Inputs to each read-pipeline stage.
  always_comb begin
    stg_v_in[0] = rd_acc;
    stg_d_in[0] = rd_word;
    for (int unsigned s = 1; s < RD_LAT; s++) begin
      stg_v_in[s] = pv_q[s-1];
      stg_d_in[s] = pd_q[s-1];
    end
  end

  // Read pipeline: data only advances with a valid so the output holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < RD_LAT; s++) begin
        pv_q[s] <= '0;
        for (int unsigned b = 0; b < NBANKS; b++) begin
          pd_q[s][b] <= '0;
        end
      end
    end else begin
      for (int unsigned s = 0; s < RD_LAT; s++) begin
        pv_q[s] <= reinit ? '0 : stg_v_in[s];
        for (int unsigned b = 0; b < NBANKS; b++) begin
          if (stg_v_in[s][b] && !reinit) begin
            pd_q[s][b] <= stg_d_in[s][b];
          end
        end
      end
    end
  end

  assign rd_valid = pv_q[RD_LAT-1];

  // Flatten the last pipeline stage onto the packed data bus.
  always_comb begin
    rd_data = '0;
    for (int unsigned b = 0; b < NBANKS; b++) begin
      rd_data[b*DATA_W +: DATA_W] = pd_q[RD_LAT-1][b];
    end
  end

  // Saturating illegal-access accumulation.
  always_comb begin
    err_sum   = 32'(err_cnt_q) + err_inc;
    err_cnt_d = (err_sum > 32'h0000_FFFF) ? 16'hFFFF : err_sum[15:0];
  end

  // Illegal-access counter register; survives reinit, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_hir_banked_mem_model.sv
// Scoreboard bench for hir_banked_mem_model: stimulus pushes expected read
// responses into per-bank queues; a negedge monitor pops and compares.
module tb_hir_banked_mem_model;

  localparam int unsigned NB    = 16;
  localparam int unsigned DEPTH = 12;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned LAT   = 3;
  localparam logic [31:0] ERRV  = 32'hE0E0_0BAD;

  logic              clk    = 1'b0;
  logic              rst    = 1'b1;
  logic              reinit = 1'b0;
  logic              ready;
  logic [NB-1:0]     rd_en   = '0;
  logic [NB*AW-1:0]  rd_addr = '0;
  logic [NB-1:0]     rd_valid;
  logic [NB*DW-1:0]  rd_data;
  logic [NB-1:0]     wr_en   = '0;
  logic [NB*AW-1:0]  wr_addr = '0;
  logic [NB*DW-1:0]  wr_data = '0;
  logic [15:0]       err_cnt;

  hir_banked_mem_model #(
    .NBANKS    (NB),
    .DEPTH     (DEPTH),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .RD_LAT    (LAT),
    .INIT_MODE (1),
    .INIT_CONST(255),
    .ERR_VALUE (ERRV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .reinit  (reinit),
    .ready   (ready),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
  } exp_t;

  exp_t        expq [NB][$];
  logic [31:0] ref_mem [NB][DEPTH];
  logic [31:0] last_data [NB];
  int unsigned cyc        = 0;
  int unsigned ready_from = 32'hFFFF_FFFF;
  int unsigned model_err  = 0;
  int unsigned n_chk      = 0;
  int unsigned n_pass     = 0;
  bit          mon_en     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
  endtask

  function automatic bit model_ready();
    return (rst == 1'b0) && (cyc >= ready_from);
  endfunction

  task automatic refill();
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++)
        ref_mem[b][a] = 32'(a + 1);
  endtask

  // Drop expected responses due at or after cycle 'limit'.
  task automatic purge(input int unsigned limit);
    for (int b = 0; b < NB; b++)
      while (expq[b].size() > 0 && expq[b][expq[b].size()-1].cyc >= limit)
        void'(expq[b].pop_back());
  endtask

  task automatic clear_in();
    rd_en = '0; wr_en = '0; rd_addr = '0; wr_addr = '0; wr_data = '0; reinit = 1'b0;
  endtask

  task automatic set_rd(input int unsigned b, input int unsigned a);
    rd_en[b] = 1'b1;
    rd_addr[b*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int unsigned b, input int unsigned a, input logic [31:0] d);
    wr_en[b] = 1'b1;
    wr_addr[b*AW +: AW] = AW'(a);
    wr_data[b*DW +: DW] = d;
  endtask

  task automatic rand_in();
    for (int b = 0; b < NB; b++) begin
      rd_en[b] = 1'($urandom_range(0, 1));
      wr_en[b] = 1'($urandom_range(0, 1));
      rd_addr[b*AW +: AW] = AW'($urandom_range(0, 15));
      wr_addr[b*AW +: AW] = AW'($urandom_range(0, 15));
      wr_data[b*DW +: DW] = $urandom;
    end
  endtask

  // Apply the access rules to the inputs of the current cycle, then advance.
  task automatic step();
    bit          acc;
    bit          do_reinit;
    int unsigned inc;
    int unsigned a;
    exp_t        e;
    inc       = 0;
    do_reinit = reinit;
    acc       = model_ready() && !reinit;
    if (acc) begin
      for (int b = 0; b < NB; b++) begin
        if (rd_en[b]) begin
          a     = 32'(rd_addr[b*AW +: AW]);
          e.cyc = cyc + LAT;
          if (a < DEPTH) e.data = ref_mem[b][a];
          else begin e.data = ERRV; inc++; end
          expq[b].push_back(e);
        end
      end
      for (int b = 0; b < NB; b++) begin
        if (wr_en[b]) begin
          a = 32'(wr_addr[b*AW +: AW]);
          if (a < DEPTH) ref_mem[b][a] = wr_data[b*DW +: DW];
          else inc++;
        end
      end
    end
    if (do_reinit) purge(cyc + 1);
    @(posedge clk); #1;
    model_err = (model_err + inc > 65535) ? 65535 : model_err + inc;
    if (do_reinit) begin
      refill();
      ready_from = cyc + DEPTH;
    end
  endtask

  task automatic reset_assert();
    rst = 1'b1;
    purge(cyc);
    model_err  = 0;
    ready_from = 32'hFFFF_FFFF;
    for (int b = 0; b < NB; b++) last_data[b] = '0;
  endtask

  task automatic reset_release();
    rst = 1'b0;
    refill();
    ready_from = cyc + DEPTH;
  endtask

  task automatic drain(input int unsigned n);
    clear_in();
    repeat (n) step();
  endtask

  task automatic fill_wait();
    repeat (DEPTH) begin rand_in(); step(); end
    clear_in();
  endtask

  // Monitor: compares outputs against the scoreboard every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [31:0] d;
      exp_t        e;
      check("ready", 32'(ready), 32'(model_ready()));
      check("err_cnt", 32'(err_cnt), 32'(model_err[15:0]));
      for (int b = 0; b < NB; b++) begin
        d = rd_data[b*DW +: DW];
        if (rd_valid[b] === 1'b1) begin
          if (expq[b].size() == 0) begin
            check("rd_valid_spurious", 32'(1), 32'(0));
          end else begin
            e = expq[b].pop_front();
            check("rd_latency", cyc, e.cyc);
            check("rd_data", d, e.data);
            last_data[b] = e.data;
          end
        end else begin
          check("rd_valid_low", 32'(rd_valid[b]), 32'(0));
          check("rd_data_hold", d, last_data[b]);
          if (expq[b].size() > 0 && expq[b][0].cyc <= cyc) begin
            check("rd_valid_missing", 32'(0), 32'(1));
            void'(expq[b].pop_front());
          end
        end
      end
    end
  end

  initial begin
    clear_in();
    @(posedge clk); #1;
    reset_assert();
    mon_en = 1;
    repeat (3) begin rand_in(); step(); end
    clear_in();
    reset_release();
    fill_wait();

    // Single read, bank 3 addr 5.
    set_rd(3, 5); step(); drain(LAT + 1);

    // Back-to-back reads of the last word on every bank.
    repeat (20) begin
      clear_in();
      for (int b = 0; b < NB; b++) set_rd(b, DEPTH - 1);
      step();
    end
    drain(LAT + 1);

    // Read-first on same bank and address, then the new word.
    set_wr(7, 2, 32'hDEAD); set_rd(7, 2); step();
    clear_in(); set_rd(7, 2); step();
    drain(LAT + 1);

    // Out-of-range read and write in the same cycle.
    set_rd(0, 13); set_wr(0, 14, 32'h1234); step();
    drain(LAT + 1);
    check("oob_err_cnt", 32'(err_cnt), 32'd2);
    for (int a = 0; a < DEPTH; a++) begin clear_in(); set_rd(0, a); step(); end
    drain(LAT + 1);

    // Every port out of range in one cycle.
    for (int b = 0; b < NB; b++) begin set_rd(b, 15); set_wr(b, 12, 32'h5555); end
    step(); drain(LAT + 1);

    // Reinit after overwriting addr 0; accesses during fill are ignored.
    set_wr(0, 0, 32'hBEEF); step();
    clear_in(); set_rd(0, 0); step();
    drain(LAT + 1);
    reinit = 1'b1; step(); reinit = 1'b0;
    fill_wait();
    set_rd(0, 0); step(); drain(LAT + 1);

    // Randomized traffic with occasional reinit.
    repeat (400) begin
      rand_in();
      reinit = ($urandom_range(0, 59) == 0);
      step();
    end
    drain(LAT + 2);
    fill_wait();

    // Reset in the middle of a fill.
    reset_assert(); step(); step();
    reset_release();
    repeat (7) begin rand_in(); step(); end
    reset_assert(); step(); step();
    reset_release();
    fill_wait();

    // Reset in the middle of a read burst.
    repeat (5) begin
      clear_in();
      for (int b = 0; b < NB; b++) set_rd(b, $urandom_range(0, DEPTH - 1));
      step();
    end
    reset_assert(); clear_in(); step(); step();
    reset_release();
    fill_wait();

    // Drive the error counter into saturation.
    repeat (2060) begin
      for (int b = 0; b < NB; b++) begin set_rd(b, 15); set_wr(b, 13, 32'h0); end
      step();
    end
    drain(LAT + 1);
    check("err_saturated", 32'(err_cnt), 32'h0000_FFFF);
    reinit = 1'b1; step(); reinit = 1'b0;
    fill_wait();
    check("err_kept_over_reinit", 32'(err_cnt), 32'h0000_FFFF);

    drain(LAT + 2);
    for (int b = 0; b < NB; b++) check("queue_empty", 32'(expq[b].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
